// File: rtl/k_rctl_t3.sv
// Read-side controller for the dual-clock gray-pointer FIFO: read pointers, RAM read address,
// registered empty/almost-empty/occupancy. Define K_RCTL_UFLOW_EN to add the sticky underflow flag.
module k_rctl_t3 #(
    parameter int addr_size = 4,
    parameter int aempty_th = 2
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [addr_size:0]   rq2_wptr,
    input  logic                 rget,
    output logic [addr_size-1:0] raddr,
    output logic [addr_size:0]   rptr,
    output logic                 rempty,
    output logic                 raempty,
    output logic [addr_size:0]   rcount
`ifdef K_RCTL_UFLOW_EN
    ,
    input  logic                 rerr_clr,
    output logic                 rerr_uflow
`endif
);

    localparam logic [addr_size:0] AE_TH = (addr_size + 1)'(aempty_th);

    logic [addr_size:0] rbin;
    logic [addr_size:0] rbin_next;
    logic [addr_size:0] rgray_next;
    logic [addr_size:0] wbin;
    logic [addr_size:0] cnt_next;
    logic               rinc;

    assign rinc       = rget & ~rempty;
    assign rbin_next  = rbin + {{addr_size{1'b0}}, rinc};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    assign raddr      = rbin[addr_size-1:0];

    // Gray to binary: each bit is the XOR of all gray bits at or above it.
    always_comb begin
        wbin = '0;
        wbin[addr_size] = rq2_wptr[addr_size];
        for (int i = addr_size - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rq2_wptr[i];
        end
    end

    // Modulo subtraction keeps occupancy correct across the pointer wrap.
    assign cnt_next = wbin - rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin    <= '0;
            rptr    <= '0;
            rempty  <= 1'b1;
            raempty <= 1'b1;
            rcount  <= '0;
        end else begin
            rbin    <= rbin_next;
            rptr    <= rgray_next;
            rempty  <= (rgray_next == rq2_wptr);
            raempty <= (cnt_next <= AE_TH);
            rcount  <= cnt_next;
        end
    end

`ifdef K_RCTL_UFLOW_EN
    // Set wins over clear so an underflow in the clearing cycle is not lost.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rerr_uflow <= 1'b0;
        end else if (rget && rempty) begin
            rerr_uflow <= 1'b1;
        end else if (rerr_clr) begin
            rerr_uflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_k_rctl_t3.sv
// Bench for k_rctl_t3: directed and random stimulus against a word-count model,
// with expectations queued per cycle and checked by an independent monitor.
module tb_k_rctl_t3;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int AE    = 2;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic [AW:0]   rq2_wptr = '0;
    logic          rget = 1'b0;
    logic          rerr_clr = 1'b0;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rcount;
    logic          rerr_uflow;

    k_rctl_t3 #(.addr_size(AW), .aempty_th(AE)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rq2_wptr (rq2_wptr),
        .rget     (rget),
        .raddr    (raddr),
        .rptr     (rptr),
        .rempty   (rempty),
        .raempty  (raempty),
        .rcount   (rcount)
`ifdef K_RCTL_UFLOW_EN
        ,
        .rerr_clr   (rerr_clr),
        .rerr_uflow (rerr_uflow)
`endif
    );

`ifndef K_RCTL_UFLOW_EN
    assign rerr_uflow = 1'b0;
`endif

    always #5 rclk = ~rclk;

    typedef struct {
        int addr;
        int ptr;
        bit empty;
        bit aempty;
        int count;
        bit uf;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: total words written and read since reset, plus the visible empty flag.
    int W = 0;
    int R = 0;
    bit m_empty = 1'b1;
    bit m_uf = 1'b0;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    task automatic drive(input bit get, input int wadv, input bit clr);
        exp_t e;
        int adv;
        bit pop;
        adv = wadv;
        if (W + adv - R > DEPTH) adv = DEPTH - (W - R);
        if (adv < 0) adv = 0;
        W = W + adv;
        rq2_wptr = (AW + 1)'(gray(W % (2 * DEPTH)));
        rget = get;
        rerr_clr = clr;
        pop = get && !m_empty;
        if (get && m_empty) m_uf = 1'b1;
        else if (clr) m_uf = 1'b0;
        if (pop) R = R + 1;
        m_empty = (W - R) == 0;
        e.addr   = R % DEPTH;
        e.ptr    = gray(R % (2 * DEPTH));
        e.empty  = m_empty;
        e.aempty = (W - R) <= AE;
        e.count  = W - R;
        e.uf     = m_uf;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit get, input int wadv, input bit clr);
        @(negedge rclk);
        drive(get, wadv, clr);
    endtask

    task automatic settle();
        @(posedge rclk);
        #2;
    endtask

    // Assert reset mid-cycle, check outputs at once, release with W words already present.
    task automatic do_reset(input int w0);
        @(negedge rclk);
        #2;
        rrst_n = 1'b0;
        rget = 1'b1;
        rerr_clr = 1'b0;
        W = w0;
        R = 0;
        m_empty = 1'b1;
        m_uf = 1'b0;
        rq2_wptr = (AW + 1)'(gray(W % (2 * DEPTH)));
        #1;
        chk("rst_rempty", int'(rempty), 1);
        chk("rst_raempty", int'(raempty), 1);
        chk("rst_rcount", int'(rcount), 0);
        chk("rst_rptr", int'(rptr), 0);
        chk("rst_raddr", int'(raddr), 0);
        chk("rst_uflow", int'(rerr_uflow), 0);
        rget = 1'b0;
        repeat (2) @(negedge rclk);
        rrst_n = 1'b1;
        drive(1'b0, 0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge rclk);
            #1;
            if (rrst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("raddr", int'(raddr), e.addr);
                chk("rptr", int'(rptr), e.ptr);
                chk("rempty", int'(rempty), int'(e.empty));
                chk("raempty", int'(raempty), int'(e.aempty));
                chk("rcount", int'(rcount), e.count);
`ifdef K_RCTL_UFLOW_EN
                chk("rerr_uflow", int'(rerr_uflow), int'(e.uf));
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        do_reset(3);
        settle();
        chk("post_rst_rcount", int'(rcount), 3);
        chk("post_rst_rempty", int'(rempty), 0);

        // Fill and drain: the fourth pop lands on an empty FIFO and is ignored.
        repeat (4) step(1'b1, 0, 1'b0);
        settle();
        chk("drain_rptr", int'(rptr), 5'b00010);
        chk("drain_raddr", int'(raddr), 3);
        chk("drain_rempty", int'(rempty), 1);

        // Last word popped while a new one arrives.
        step(1'b0, 1, 1'b0);
        step(1'b1, 1, 1'b0);
        settle();
        chk("simul_rcount", int'(rcount), 1);
        chk("simul_rempty", int'(rempty), 0);

        // Wrap: two full passes of 16 writes then 16 pops.
        do_reset(0);
        for (int pass = 0; pass < 2; pass++) begin
            repeat (DEPTH) step(1'b0, 1, 1'b0);
            settle();
            chk("full_rcount", int'(rcount), DEPTH);
            chk("full_rempty", int'(rempty), 0);
            chk("full_raempty", int'(raempty), 0);
            repeat (DEPTH) step(1'b1, 0, 1'b0);
            settle();
            chk("wrap_rptr", int'(rptr), (pass == 0) ? 5'b11000 : 0);
            chk("wrap_raddr", int'(raddr), 0);
            chk("wrap_rempty", int'(rempty), 1);
            chk("wrap_rcount", int'(rcount), 0);
        end

`ifdef K_RCTL_UFLOW_EN
        step(1'b1, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        settle();
        chk("uflow_held", int'(rerr_uflow), 1);
        step(1'b0, 0, 1'b1);
        settle();
        chk("uflow_clr", int'(rerr_uflow), 0);
        step(1'b1, 0, 1'b0);
        step(1'b1, 0, 1'b1);
        settle();
        chk("uflow_set_prio", int'(rerr_uflow), 1);
`endif

        for (int i = 0; i < 600; i++) begin
            if (($urandom % 150) == 0) begin
                do_reset(int'($urandom_range(0, DEPTH)));
            end else begin
                step(1'($urandom), int'($urandom_range(0, 2)), ($urandom % 8) == 0);
            end
        end

        step(1'b0, 0, 1'b0);
        repeat (3) @(negedge rclk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/k_rctl_t3.md
Name: k_rctl_t3

Overview:
Parametrised read-side controller for the dual-clock gray-pointer FIFO. It runs entirely in the read clock domain. It holds the binary and gray read pointers and drives the RAM read address. It also produces registered empty, almost-empty and fill-level outputs from the write pointer that is synchronised into this domain. It replaces the previous read-control/empty pair and adds an occupancy count, a parametrised almost-empty threshold and an optional underflow detector.

Parameters:
addr_size, 4, RAM address width; FIFO depth = 2**addr_size
aempty_th, 2, raempty asserts when occupancy <= aempty_th; legal range 0..2**addr_size-1

Ports:
rclk  input  1  read clock; all state on rising edge
rrst_n  input  1  asynchronous active-low reset
rq2_wptr  input  addr_size+1  gray write pointer, already 2-flop synchronised into rclk
rget  input  1  pop request; honoured only when rempty=0
raddr  output  addr_size  RAM read address = low addr_size bits of binary read pointer
rptr  output  addr_size+1  gray read pointer, registered, to the write-domain synchroniser
rempty  output  1  registered empty flag
raempty  output  1  registered almost-empty flag
rcount  output  addr_size+1  registered occupancy, 0..2**addr_size
rerr_clr  input  1  clears rerr_uflow (present only with K_RCTL_UFLOW_EN)
rerr_uflow  output  1  sticky underflow flag (present only with K_RCTL_UFLOW_EN)

Behaviour:
- Reset (async assert, sync release on rclk): rbin=0, rptr=0, raddr=0, rempty=1, raempty=1, rcount=0, rerr_uflow=0.
- rinc = rget & ~rempty.
- rbin_next = rbin + rinc, modulo 2**(addr_size+1).
- rgray_next = (rbin_next>>1) ^ rbin_next.
- rbin and rptr register rbin_next and rgray_next. raddr = rbin[addr_size-1:0], so it is valid in the same cycle rempty=0.
- wbin = gray-to-binary of rq2_wptr (XOR prefix from MSB), combinational.
- cnt_next = wbin - rbin_next, modulo 2**(addr_size+1).
- Registered on each edge: rempty <= (rgray_next == rq2_wptr); rcount <= cnt_next; raempty <= (cnt_next <= aempty_th).
- Latency: a change on rq2_wptr is reflected in rempty, rcount and raempty one rclk edge later. A pop is reflected in raddr, rptr and the flags on the same edge.
- Simultaneous pop and wptr advance: both are applied in cnt_next. If the last word is popped in the same cycle a new word arrives, the result is rempty=0 and rcount=1.
- rget while rempty=1: pointer holds, flags unchanged. This is not an error unless the macro below is defined.
- Wrap-around: rbin rolls from 2**(addr_size+1)-1 to 0. The MSB distinguishes passes. rcount stays correct across the wrap through modulo subtraction.
- Full FIFO (wbin - rbin = 2**addr_size): rcount = 2**addr_size, rempty=0, raempty=0 unless aempty_th >= 2**addr_size (not legal).
- rq2_wptr must never run more than 2**addr_size ahead of rbin. Behaviour outside that range is undefined; the write side guarantees it.
- Reset mid-operation: all outputs return to their reset values immediately, whatever the rget or rq2_wptr activity.
- No combinational path from rget or rq2_wptr to any output except raddr through the registers; all outputs are registered.

Optional Feature:
Macro K_RCTL_UFLOW_EN.
- Defined: ports rerr_clr and rerr_uflow exist.
  - rerr_uflow sets on any edge where rget=1 and rempty=1, and stays set until a cycle with rerr_clr=1.
  - Set has priority if set and clear occur in the same cycle.
  - Pointer behaviour is identical to the undefined case.
- Undefined: both ports and their logic are absent; rget on empty is silently ignored.

Test Plan:
- Reset check: assert rrst_n=0 mid-clock with rq2_wptr=5'b00010 -> immediately rempty=1, raempty=1, rcount=0, rptr=0, raddr=0; after release, first edge gives rcount=3, rempty=0, raempty=0 (aempty_th=2).
- Fill and drain: rq2_wptr=gray(3)=5'b00010, then rget=1 for 4 cycles -> raddr 0,1,2,3 (held); rcount 3,2,1,0; raempty=1 once rcount<=2; rempty=1 after the third pop; the fourth pop is ignored and rptr stays at gray(3).
- Simultaneous pop and write: rcount=1, rget=1 and rq2_wptr advances by one in the same cycle -> next edge rcount=1, rempty=0.
- Wrap: repeat 16 writes then 16 pops, twice -> after the first pass rptr=gray(16)=5'b11000 and raddr=0; after the second pass rbin=0 and rptr=0; rempty=1 and rcount=0 at the end of each pass.
- Full: rq2_wptr=gray(16) with rbin=0 -> rcount=16, rempty=0, raempty=0.
- Underflow (K_RCTL_UFLOW_EN defined): rget=1 while rempty=1 -> rerr_uflow=1 next edge and held; rerr_clr=1 for one cycle -> rerr_uflow=0; rerr_clr and an underflow in the same cycle -> rerr_uflow stays 1.
